layer_argmax_reader: RTL and testbench

//  Reader side of the hidden-layer output interface. Waits for the layer's done

---
 rtl/mnist_pkg.sv | 20 ++
 rtl/layer_argmax_reader_argmax_step.sv | 30 +++
 rtl/layer_argmax_reader.sv | 123 ++++++++++++
 tb/tb_layer_argmax_reader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mnist_pkg.sv
// Shared sizing, FSM state encoding and score helpers for the MNIST output stage.
package mnist_pkg;

   localparam int unsigned NUM_CLASSES = 10;
   localparam int unsigned SCORE_BITS  = 24;
   localparam int unsigned IDX_BITS    = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      SCAN    = 2'd2,
      VALID   = 2'd3
   } state_t;

   // Bit pattern of the most-negative two's complement value of the given width.
   function automatic logic [63:0] most_negative(input int unsigned bits);
      return 64'(1) << (bits - 32'd1);
   endfunction

endpackage

// File: rtl/layer_argmax_reader_argmax_step.sv
// One compare step of the running top-two search: folds a candidate score into
// the current best/second pair. Ties never displace the incumbent.
module argmax_step #(
   parameter int unsigned SCORE_BITS = mnist_pkg::SCORE_BITS,
   parameter int unsigned IDX_BITS   = mnist_pkg::IDX_BITS
) (
   input  logic signed [SCORE_BITS-1:0] cand,
   input  logic        [IDX_BITS-1:0]   cand_idx,
   input  logic signed [SCORE_BITS-1:0] best,
   input  logic        [IDX_BITS-1:0]   best_idx,
   input  logic signed [SCORE_BITS-1:0] second,
   output logic signed [SCORE_BITS-1:0] new_best_c,
   output logic        [IDX_BITS-1:0]   new_best_idx_c,
   output logic signed [SCORE_BITS-1:0] new_second_c
);

   always_comb begin
      new_best_c     = best;
      new_best_idx_c = best_idx;
      new_second_c   = second;
      if (cand > best) begin
         new_second_c   = best;
         new_best_c     = cand;
         new_best_idx_c = cand_idx;
      end else if (cand > second) begin
         new_second_c = cand;
      end
   end

endmodule

// File: rtl/layer_argmax_reader.sv
// Snapshots the last layer's class scores on its done edge, scans them one per
// clock for the winner and runner-up, and offers digit/score/margin downstream.
module layer_argmax_reader #(
   parameter int unsigned NUM_CLASSES = mnist_pkg::NUM_CLASSES,
   parameter int unsigned SCORE_BITS  = mnist_pkg::SCORE_BITS,
   parameter int unsigned IDX_BITS    = mnist_pkg::IDX_BITS
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         layer_done,
   input  logic signed [SCORE_BITS-1:0] scores [0:NUM_CLASSES-1],
   output logic                         busy,
   output logic                         result_valid,
   input  logic                         result_ready,
   output logic        [IDX_BITS-1:0]   digit,
   output logic signed [SCORE_BITS-1:0] max_score,
   output logic        [SCORE_BITS:0]   margin,
   output logic                         overrun
);

   import mnist_pkg::*;

   localparam logic signed [SCORE_BITS-1:0] MOST_NEG = SCORE_BITS'(most_negative(SCORE_BITS));
   localparam logic        [IDX_BITS-1:0]   LAST_IDX = IDX_BITS'(NUM_CLASSES - 1);

   state_t                       state;
   logic                         done_q;
   logic signed [SCORE_BITS-1:0] snap [0:NUM_CLASSES-1];
   logic signed [SCORE_BITS-1:0] best;
   logic signed [SCORE_BITS-1:0] second;
   logic        [IDX_BITS-1:0]   best_idx;
   logic        [IDX_BITS-1:0]   idx;

   logic                         done_edge_c;
   logic signed [SCORE_BITS-1:0] step_best_c;
   logic signed [SCORE_BITS-1:0] step_second_c;
   logic        [IDX_BITS-1:0]   step_idx_c;
   logic        [SCORE_BITS:0]   margin_c;

   assign done_edge_c = layer_done & ~done_q;

   argmax_step #(
      .SCORE_BITS (SCORE_BITS),
      .IDX_BITS   (IDX_BITS)
   ) u_step (
      .cand           (snap[idx]),
      .cand_idx       (idx),
      .best           (best),
      .best_idx       (best_idx),
      .second         (second),
      .new_best_c     (step_best_c),
      .new_best_idx_c (step_idx_c),
      .new_second_c   (step_second_c)
   );

   // One extra bit keeps best - second exact even for full-range extremes.
   assign margin_c = {step_best_c[SCORE_BITS-1], step_best_c}
                   - {step_second_c[SCORE_BITS-1], step_second_c};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         done_q       <= 1'b0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         overrun      <= 1'b0;
         digit        <= '0;
         max_score    <= '0;
         margin       <= '0;
         best         <= '0;
         second       <= '0;
         best_idx     <= '0;
         idx          <= '0;
         for (int k = 0; k < int'(NUM_CLASSES); k++) begin
            snap[k] <= '0;
         end
      end else begin
         done_q  <= layer_done;
         // A done edge that arrives while a result is in flight is dropped and flagged.
         overrun <= done_edge_c && (state != IDLE);
         case (state)
            IDLE: begin
               if (done_edge_c) begin
                  snap  <= scores;
                  busy  <= 1'b1;
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               best     <= snap[0];
               best_idx <= '0;
               second   <= MOST_NEG;
               idx      <= IDX_BITS'(1);
               state    <= SCAN;
            end
            SCAN: begin
               best     <= step_best_c;
               best_idx <= step_idx_c;
               second   <= step_second_c;
               idx      <= idx + IDX_BITS'(1);
               if (idx == LAST_IDX) begin
                  digit        <= step_idx_c;
                  max_score    <= step_best_c;
                  margin       <= margin_c;
                  result_valid <= 1'b1;
                  state        <= VALID;
               end
            end
            VALID: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_layer_argmax_reader.sv
// Bench for layer_argmax_reader: directed table, handshake/overrun/reset corners,
// and random score sets checked against a top-two reference model.
module tb_layer_argmax_reader;

   localparam int NC = 10;
   localparam int SB = 24;
   localparam int IB = 4;

   typedef logic [NC-1:0][SB-1:0] svec_t;

   typedef struct {
      svec_t  s;
      int     d;
      longint mx;
      longint mg;
      int     hold;
      bit     edge_acc;
   } case_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 layer_done;
   logic signed [SB-1:0] scores [0:NC-1];
   logic                 busy;
   logic                 result_valid;
   logic                 result_ready;
   logic        [IB-1:0] digit;
   logic signed [SB-1:0] max_score;
   logic        [SB:0]   margin;
   logic                 overrun;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   layer_argmax_reader dut (
      .clk          (clk),
      .rst          (rst),
      .layer_done   (layer_done),
      .scores       (scores),
      .busy         (busy),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .digit        (digit),
      .max_score    (max_score),
      .margin       (margin),
      .overrun      (overrun)
   );

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic svec_t from_ints(input int v [NC]);
      svec_t r;
      for (int k = 0; k < NC; k++) r[k] = SB'(v[k]);
      return r;
   endfunction

   // Winner = largest score, lowest index on ties; runner-up = largest of the rest.
   task automatic ref_model(input svec_t s, output int d, output longint mx, output longint mg);
      longint v;
      longint sec;
      d  = 0;
      mx = $signed(s[0]);
      for (int k = 1; k < NC; k++) begin
         v = $signed(s[k]);
         if (v > mx) begin
            mx = v;
            d  = k;
         end
      end
      sec = -(longint'(1) << 40);
      for (int k = 0; k < NC; k++) begin
         v = $signed(s[k]);
         if (k != d && v > sec) sec = v;
      end
      mg = mx - sec;
   endtask

   task automatic drive_scores(input svec_t s);
      for (int k = 0; k < NC; k++) scores[k] = s[k];
   endtask

   task automatic run_txn(input string nm, input svec_t s, input int ed, input longint emx,
                          input longint emg, input int hold, input bit edge_acc);
      int cyc;
      bit got;
      bit stable;
      @(negedge clk);
      drive_scores(s);
      layer_done = 1'b1;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) chk({nm, " busy"}, busy, 1);
         if (cyc == 2) begin
            // The layer may restart: drop done and scramble the live scores.
            layer_done = 1'b0;
            for (int k = 0; k < NC; k++) scores[k] = SB'($urandom);
         end
         got = result_valid;
      end
      chk({nm, " latency"}, cyc, 11);
      chk({nm, " digit"}, digit, ed);
      chk({nm, " max_score"}, max_score, emx);
      chk({nm, " margin"}, margin, emg);
      stable = 1'b1;
      repeat (hold) begin
         @(negedge clk);
         if (!result_valid || int'(digit) != ed || longint'(max_score) != emx
             || longint'(margin) != emg || !busy)
            stable = 1'b0;
      end
      if (hold > 0) chk({nm, " hold stable"}, stable, 1);
      result_ready = 1'b1;
      if (edge_acc) layer_done = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      chk({nm, " valid after accept"}, result_valid, 0);
      chk({nm, " busy after accept"}, busy, 0);
      chk({nm, " digit kept"}, digit, ed);
      if (edge_acc) begin
         chk({nm, " overrun at accept"}, overrun, 1);
         repeat (3) @(negedge clk);
         chk({nm, " no retrigger"}, busy, 0);
         layer_done = 1'b0;
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, " busy"}, busy, 0);
      chk({nm, " result_valid"}, result_valid, 0);
      chk({nm, " digit"}, digit, 0);
      chk({nm, " max_score"}, max_score, 0);
      chk({nm, " margin"}, margin, 0);
      chk({nm, " overrun"}, overrun, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      case_t  tbl [5];
      int     v1 [NC];
      int     v2 [NC];
      int     v3 [NC];
      int     v5 [NC];
      int     allhi [NC];
      int     cyc;
      int     rd;
      longint rmx;
      longint rmg;
      svec_t  rs;
      int     mode;

      v1 = '{5, -3, 7, 2, 0, 1, -8, 6, 4, 3};
      v5 = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 9};
      for (int k = 0; k < NC; k++) begin
         v2[k]    = -100;
         v3[k]    = -8388608;
         allhi[k] = 100;
      end
      v3[9] = 8388607;

      tbl[0] = '{from_ints(v1), 2, 7, 1, 0, 1'b0};
      tbl[1] = '{from_ints(v2), 0, -100, 0, 0, 1'b0};
      tbl[2] = '{from_ints(v3), 9, 8388607, 16777215, 0, 1'b0};
      tbl[3] = '{from_ints(v1), 2, 7, 1, 20, 1'b0};
      tbl[4] = '{from_ints(v5), 8, 9, 0, 2, 1'b1};

      rst          = 1'b1;
      layer_done   = 1'b0;
      result_ready = 1'b0;
      for (int k = 0; k < NC; k++) scores[k] = '0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      for (int t = 0; t < 5; t++) begin
         run_txn($sformatf("tbl%0d", t), tbl[t].s, tbl[t].d, tbl[t].mx, tbl[t].mg,
                 tbl[t].hold, tbl[t].edge_acc);
      end

      // Second done edge during the scan must not disturb the first result.
      @(negedge clk);
      drive_scores(from_ints(v1));
      layer_done = 1'b1;
      cyc = 0;
      while (!result_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (cyc == 2) layer_done = 1'b0;
         if (cyc == 3) begin
            drive_scores(from_ints(allhi));
            layer_done = 1'b1;
         end
         if (cyc == 4) chk("scan overrun pulse", overrun, 1);
         if (cyc == 5) chk("scan overrun end", overrun, 0);
      end
      chk("ovr latency", cyc, 11);
      chk("ovr digit", digit, 2);
      chk("ovr max_score", max_score, 7);
      chk("ovr margin", margin, 1);
      layer_done   = 1'b0;
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      chk("ovr accept", result_valid, 0);

      // Reset in the middle of a scan clears everything at once.
      drive_scores(from_ints(v3));
      layer_done = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      chk_all_zero("midscan rst");
      @(negedge clk);
      rst        = 1'b0;
      layer_done = 1'b0;
      @(negedge clk);
      chk("post rst idle", busy, 0);
      run_txn("after rst", from_ints(v1), 2, 7, 1, 0, 1'b0);

      for (int n = 0; n < 30; n++) begin
         mode = int'($urandom_range(0, 2));
         for (int k = 0; k < NC; k++) begin
            case (mode)
               0:       rs[k] = SB'($urandom);
               1:       rs[k] = SB'(int'($urandom_range(0, 4)) - 2);
               default: rs[k] = ($urandom_range(0, 1) == 1) ? 24'h7FFFFF : 24'h800000;
            endcase
         end
         ref_model(rs, rd, rmx, rmg);
         run_txn($sformatf("rnd%0d", n), rs, rd, rmx, rmg, int'($urandom_range(0, 3)),
                 $urandom_range(0, 3) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
